router_out_fifo: RTL

ROUTER_OUT_FIFO -- requirements
Module: router_out_fifo

---
 rtl/router_pkg.sv | 19 +
 rtl/router_fifo_timer.sv | 47 ++++
 rtl/router_out_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants for the router output FIFO: default geometry, read
// timeout, and where the header flag and packet length live in an entry.
package router_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 30;

    // Header byte layout: bits [7:2] carry the payload length.
    localparam int PKT_LEN_MSB = 7;
    localparam int PKT_LEN_LSB = 2;
    localparam int PKT_CNT_W   = 6;

    // The header flag is stored one bit above the payload byte.
    function automatic int hdr_flag_bit(input int width);
        return width;
    endfunction

endpackage

// File: rtl/router_fifo_timer.sv
// Read-timeout watchdog: counts consecutive cycles where data waits unread
// and requests a flush, echoed one cycle later as the soft_reset pulse.
module router_fifo_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd_enb,
    output logic flush,
    output logic soft_reset
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count_reg, count_next;
    logic          soft_reset_reg;
    logic          waiting;

    assign waiting    = vld && !rd_enb;
    assign flush      = waiting && (count_reg == CNT_LAST);
    assign soft_reset = soft_reset_reg;

    always_comb begin
        count_next = count_reg;
        if (!waiting || flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_reg      <= '0;
            soft_reset_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            soft_reset_reg <= flush;
        end
    end

endmodule

// File: rtl/router_out_fifo.sv
// Per-port router output FIFO: header-tagged byte storage, registered read
// data, packet length tracking and a read-timeout flush.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset
);

    localparam int AW       = $clog2(DEPTH);
    localparam int FLAG_BIT = hdr_flag_bit(WIDTH);
    localparam logic [AW:0]          PTR_ONE = (AW + 1)'(1);
    localparam logic [PKT_CNT_W-1:0] PKT_ONE = PKT_CNT_W'(1);

    logic [WIDTH:0] mem [DEPTH];

    logic [AW:0]          wr_ptr_reg, wr_ptr_next;
    logic [AW:0]          rd_ptr_reg, rd_ptr_next;
    logic [WIDTH-1:0]     data_out_reg, data_out_next;
    logic [PKT_CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [WIDTH:0]       rd_entry;
    logic                 flush;
    logic                 do_write;
    logic                 do_read;

    // The extra wrap bit separates a full ring from an empty one.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign vld_out = !empty;

    assign do_write = write_enb && !full && !flush;
    assign do_read  = rd_enb && !empty && !flush;
    assign rd_entry = mem[rd_ptr_reg[AW-1:0]];
    assign data_out = data_out_reg;

    router_fifo_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clock     (clock),
        .resetn    (resetn),
        .vld       (vld_out),
        .rd_enb    (rd_enb),
        .flush     (flush),
        .soft_reset(soft_reset)
    );

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        data_out_next = data_out_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            data_out_next = '0;
            pkt_cnt_next  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr_next   = rd_ptr_reg + PTR_ONE;
                data_out_next = rd_entry[WIDTH-1:0];
                // Header load covers the payload plus the trailing parity byte.
                if (rd_entry[FLAG_BIT]) begin
                    pkt_cnt_next = rd_entry[PKT_LEN_MSB:PKT_LEN_LSB] + PKT_ONE;
                end else if (pkt_cnt_reg != '0) begin
                    pkt_cnt_next = pkt_cnt_reg - PKT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            data_out_reg <= '0;
            pkt_cnt_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            data_out_reg <= data_out_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    // Storage is deliberately left out of reset; pointers guard stale reads.
    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
        end
    end

endmodule
